// File: rtl/level_book_pkg.sv
// Shared types for the price-level aggregate order book.
package level_book_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_MATCH  = 2'b01,
    OP_CANCEL = 2'b10,
    OP_RSVD   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MATCH = 2'd1,
    S_SCAN  = 2'd2
  } state_t;

  localparam logic SIDE_BID = 1'b0;
  localparam logic SIDE_ASK = 1'b1;

endpackage

// File: rtl/level_array.sv
// One side of the book: per-level quantity storage, best pointer and valid flag.
// DIR selects whether "better" means higher (bids) or lower (asks) price.
module level_array
  import level_book_pkg::*;
#(
  parameter int   QTY_WIDTH    = 32,
  parameter int   PRICE_LEVELS = 256,
  parameter int   PRICE_WIDTH  = $clog2(PRICE_LEVELS),
  parameter logic DIR          = SIDE_BID
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PRICE_WIDTH-1:0] addr,
  output logic [QTY_WIDTH-1:0]   rd_qty,
  input  logic                   wr_en,
  input  logic [QTY_WIDTH-1:0]   wr_qty,
  input  logic                   add_en,
  input  logic                   scan_en,
  output logic                   scan_done,
  output logic [PRICE_WIDTH-1:0] best,
  output logic                   valid
);

  // The far end of the side doubles as the reset value of the best pointer.
  localparam logic [PRICE_WIDTH-1:0] END_PRICE =
    (DIR == SIDE_ASK) ? PRICE_WIDTH'(PRICE_LEVELS - 1) : '0;

  logic [QTY_WIDTH-1:0]   levels [PRICE_LEVELS];
  logic [PRICE_WIDTH-1:0] next_price;
  logic                   at_end;
  logic                   improves;

  assign next_price = (DIR == SIDE_ASK) ? best + PRICE_WIDTH'(1) : best - PRICE_WIDTH'(1);
  assign at_end     = (best == END_PRICE);
  assign rd_qty     = levels[addr];
  assign scan_done  = at_end || (levels[next_price] != '0);
  assign improves   = !valid || ((DIR == SIDE_ASK) ? (addr < best) : (addr > best));

  // Scan looks one level ahead so the pointer lands on the new best in the same step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < PRICE_LEVELS; i++) levels[i] <= '0;
      best  <= END_PRICE;
      valid <= 1'b0;
    end else begin
      if (wr_en) levels[addr] <= wr_qty;
      if (add_en && improves) begin
        best  <= addr;
        valid <= 1'b1;
      end else if (scan_en) begin
        if (at_end) valid <= 1'b0;
        else        best  <= next_price;
      end
    end
  end

endmodule

// File: rtl/level_book.sv
// Price-level aggregate book: add/cancel per level and IOC matching that walks
// the opposite side's best levels one fill per cycle.
module level_book
  import level_book_pkg::*;
#(
  parameter int QTY_WIDTH    = 32,
  parameter int PRICE_LEVELS = 256,
  parameter int PRICE_WIDTH  = $clog2(PRICE_LEVELS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op_flag,
  input  logic                   side,
  input  logic [PRICE_WIDTH-1:0] price,
  input  logic [QTY_WIDTH-1:0]   qty,
  output logic                   fill_valid,
  output logic [PRICE_WIDTH-1:0] fill_price,
  output logic [QTY_WIDTH-1:0]   fill_qty,
  output logic                   match_done,
  output logic [QTY_WIDTH-1:0]   match_residual,
  output logic [PRICE_WIDTH-1:0] best_bid,
  output logic [PRICE_WIDTH-1:0] best_ask,
  output logic                   bid_valid,
  output logic                   ask_valid,
  output logic                   error
);

  state_t                 state;
  logic [QTY_WIDTH-1:0]   rem;
  logic [PRICE_WIDTH-1:0] limit;
  logic                   agg_side;
  logic                   scan_side;
  logic                   ret_match;

  op_t                    op;
  logic                   accept;
  logic                   act_side;
  logic [PRICE_WIDTH-1:0] act_best;
  logic [PRICE_WIDTH-1:0] addr;
  logic [QTY_WIDTH-1:0]   act_qty;
  logic [QTY_WIDTH-1:0]   bid_rd;
  logic [QTY_WIDTH-1:0]   ask_rd;
  logic [QTY_WIDTH:0]     sum;
  logic [QTY_WIDTH-1:0]   fill_amt;
  logic [QTY_WIDTH-1:0]   wr_qty;
  logic                   wr_en;
  logic                   add_en;
  logic                   op_err;
  logic                   cancel_empties;
  logic                   crossing;
  logic                   fill_now;
  logic                   bid_scan_done;
  logic                   ask_scan_done;
  logic                   scan_done;

  assign op        = op_t'(op_flag);
  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign act_side  = (state == S_MATCH) ? ~agg_side : side;
  assign act_best  = act_side ? best_ask : best_bid;
  assign act_qty   = act_side ? ask_rd : bid_rd;
  assign addr      = (state == S_MATCH) ? act_best : price;
  assign sum       = {1'b0, act_qty} + {1'b0, qty};
  assign crossing  = agg_side ? (bid_valid && best_bid >= limit)
                              : (ask_valid && best_ask <= limit);
  assign fill_now  = (state == S_MATCH) && crossing && (rem != '0);
  assign fill_amt  = (rem < act_qty) ? rem : act_qty;
  assign scan_done = scan_side ? ask_scan_done : bid_scan_done;

  assign fill_valid     = fill_now;
  assign fill_price     = fill_now ? act_best : '0;
  assign fill_qty       = fill_now ? fill_amt : '0;
  assign match_done     = (state == S_MATCH) && !fill_now;
  assign match_residual = match_done ? rem : '0;

  // Single read/modify/write to the side being touched this cycle.
  always_comb begin
    wr_en          = 1'b0;
    wr_qty         = '0;
    add_en         = 1'b0;
    op_err         = 1'b0;
    cancel_empties = 1'b0;
    if (accept) begin
      case (op)
        OP_ADD: begin
          if (qty == '0 || sum[QTY_WIDTH]) op_err = 1'b1;
          else begin
            wr_en  = 1'b1;
            wr_qty = sum[QTY_WIDTH-1:0];
            add_en = 1'b1;
          end
        end
        OP_CANCEL: begin
          if (qty == '0 || qty > act_qty) op_err = 1'b1;
          else begin
            wr_en          = 1'b1;
            wr_qty         = act_qty - qty;
            cancel_empties = (act_qty == qty) && (price == act_best);
          end
        end
        OP_MATCH: ;
        default: op_err = 1'b1;
      endcase
    end else if (fill_now) begin
      wr_en  = 1'b1;
      wr_qty = act_qty - fill_amt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      rem       <= '0;
      limit     <= '0;
      agg_side  <= 1'b0;
      scan_side <= 1'b0;
      ret_match <= 1'b0;
      error     <= 1'b0;
    end else begin
      error <= op_err;
      case (state)
        S_IDLE: begin
          if (accept && op == OP_MATCH) begin
            rem      <= qty;
            limit    <= price;
            agg_side <= side;
            state    <= S_MATCH;
          end else if (cancel_empties) begin
            scan_side <= side;
            ret_match <= 1'b0;
            state     <= S_SCAN;
          end
        end
        S_MATCH: begin
          if (fill_now) begin
            rem <= rem - fill_amt;
            if (fill_amt == act_qty) begin
              scan_side <= ~agg_side;
              ret_match <= 1'b1;
              state     <= S_SCAN;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_SCAN: begin
          if (scan_done) state <= ret_match ? S_MATCH : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  level_array #(
    .QTY_WIDTH   (QTY_WIDTH),
    .PRICE_LEVELS(PRICE_LEVELS),
    .PRICE_WIDTH (PRICE_WIDTH),
    .DIR         (SIDE_BID)
  ) u_bid (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .rd_qty   (bid_rd),
    .wr_en    (wr_en && act_side == SIDE_BID),
    .wr_qty   (wr_qty),
    .add_en   (add_en && act_side == SIDE_BID),
    .scan_en  (state == S_SCAN && scan_side == SIDE_BID),
    .scan_done(bid_scan_done),
    .best     (best_bid),
    .valid    (bid_valid)
  );

  level_array #(
    .QTY_WIDTH   (QTY_WIDTH),
    .PRICE_LEVELS(PRICE_LEVELS),
    .PRICE_WIDTH (PRICE_WIDTH),
    .DIR         (SIDE_ASK)
  ) u_ask (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .rd_qty   (ask_rd),
    .wr_en    (wr_en && act_side == SIDE_ASK),
    .wr_qty   (wr_qty),
    .add_en   (add_en && act_side == SIDE_ASK),
    .scan_en  (state == S_SCAN && scan_side == SIDE_ASK),
    .scan_done(ask_scan_done),
    .best     (best_ask),
    .valid    (ask_valid)
  );

endmodule

// File: tb/tb_level_book.sv
// Self-checking bench for level_book: directed scenarios plus random traffic
// checked against an array-based book model.
module tb_level_book;
  import level_book_pkg::*;

  localparam int QW = 32;
  localparam int PL = 256;
  localparam int PW = 8;
  localparam longint unsigned QMAX = 64'h0000_0000_FFFF_FFFF;

  typedef struct {
    int              price;
    longint unsigned qty;
  } fill_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op_flag = 2'b00;
  logic          side = 1'b0;
  logic [PW-1:0] price = '0;
  logic [QW-1:0] qty = '0;
  logic          fill_valid;
  logic [PW-1:0] fill_price;
  logic [QW-1:0] fill_qty;
  logic          match_done;
  logic [QW-1:0] match_residual;
  logic [PW-1:0] best_bid;
  logic [PW-1:0] best_ask;
  logic          bid_valid;
  logic          ask_valid;
  logic          error;

  int n_checks = 0;
  int n_fail   = 0;

  longint unsigned bid_lvl [PL];
  longint unsigned ask_lvl [PL];

  level_book #(.QTY_WIDTH(QW), .PRICE_LEVELS(PL), .PRICE_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_flag(op_flag), .side(side), .price(price), .qty(qty),
    .fill_valid(fill_valid), .fill_price(fill_price), .fill_qty(fill_qty),
    .match_done(match_done), .match_residual(match_residual),
    .best_bid(best_bid), .best_ask(best_ask),
    .bid_valid(bid_valid), .ask_valid(ask_valid), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned getLvl(input logic s, input int p);
    return s ? ask_lvl[p] : bid_lvl[p];
  endfunction

  function automatic void setLvl(input logic s, input int p, input longint unsigned v);
    if (s) ask_lvl[p] = v;
    else   bid_lvl[p] = v;
  endfunction

  // Best bid is the highest non-empty level, best ask the lowest; -1 when empty.
  function automatic int modelBest(input logic s);
    if (!s) begin
      for (int i = PL - 1; i >= 0; i--) if (bid_lvl[i] != 0) return i;
    end else begin
      for (int i = 0; i < PL; i++) if (ask_lvl[i] != 0) return i;
    end
    return -1;
  endfunction

  function automatic void clearModel();
    for (int i = 0; i < PL; i++) begin
      bid_lvl[i] = 0;
      ask_lvl[i] = 0;
    end
  endfunction

  task automatic checkBook(input string tag);
    int b;
    int a;
    b = modelBest(1'b0);
    a = modelBest(1'b1);
    checkOutput({tag, "_bid_valid"}, 64'(bid_valid), 64'(b >= 0));
    checkOutput({tag, "_ask_valid"}, 64'(ask_valid), 64'(a >= 0));
    checkOutput({tag, "_best_bid"}, 64'(best_bid), 64'((b < 0) ? 0 : b));
    checkOutput({tag, "_best_ask"}, 64'(best_ask), 64'((a < 0) ? PL - 1 : a));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_fill_valid"}, 64'(fill_valid), 64'd0);
    checkOutput({tag, "_fill_price"}, 64'(fill_price), 64'd0);
    checkOutput({tag, "_fill_qty"}, 64'(fill_qty), 64'd0);
    checkOutput({tag, "_match_done"}, 64'(match_done), 64'd0);
    checkOutput({tag, "_match_residual"}, 64'(match_residual), 64'd0);
    checkOutput({tag, "_error"}, 64'(error), 64'd0);
    checkOutput({tag, "_bid_valid"}, 64'(bid_valid), 64'd0);
    checkOutput({tag, "_ask_valid"}, 64'(ask_valid), 64'd0);
    checkOutput({tag, "_best_bid"}, 64'(best_bid), 64'd0);
    checkOutput({tag, "_best_ask"}, 64'(best_ask), 64'(PL - 1));
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic s, input int p,
                               input longint unsigned q);
    op_flag  = op;
    side     = s;
    price    = PW'(p);
    qty      = QW'(q);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (!in_ready && cycles < PL + 8) begin
      tick();
      cycles++;
    end
    checkOutput("wait_idle", 64'(in_ready), 64'd1);
  endtask

  task automatic doAdd(input logic s, input int p, input longint unsigned q);
    longint unsigned lvl;
    bit exp_err;
    lvl = getLvl(s, p);
    exp_err = (q == 0) || (lvl + q > QMAX);
    applyStimulus(OP_ADD, s, p, q);
    checkOutput("add_error", 64'(error), 64'(exp_err));
    if (!exp_err) setLvl(s, p, lvl + q);
    checkOutput("add_ready", 64'(in_ready), 64'd1);
    checkBook("add");
  endtask

  task automatic doCancel(input logic s, input int p, input longint unsigned q,
                          output int scan_cycles);
    longint unsigned lvl;
    bit exp_err;
    bit exp_scan;
    lvl = getLvl(s, p);
    exp_err  = (q == 0) || (q > lvl);
    exp_scan = !exp_err && (q == lvl) && (p == modelBest(s));
    applyStimulus(OP_CANCEL, s, p, q);
    checkOutput("cancel_error", 64'(error), 64'(exp_err));
    if (!exp_err) setLvl(s, p, lvl - q);
    checkOutput("cancel_ready", 64'(in_ready), 64'(!exp_scan));
    waitIdle(scan_cycles);
    checkBook("cancel");
  endtask

  task automatic doMatch(input logic s, input int p, input longint unsigned q,
                         output int done_cycle);
    fill_t exp_q[$];
    longint unsigned rem;
    longint unsigned f;
    int b;
    int idx;
    int first_fill;
    rem = q;
    while (rem > 0) begin
      b = modelBest(!s);
      if (b < 0) break;
      if (s == 1'b0 ? (b > p) : (b < p)) break;
      f = (rem < getLvl(!s, b)) ? rem : getLvl(!s, b);
      exp_q.push_back('{price: b, qty: f});
      setLvl(!s, b, getLvl(!s, b) - f);
      rem -= f;
    end
    applyStimulus(OP_MATCH, s, p, q);
    idx = 0;
    first_fill = 0;
    done_cycle = 0;
    for (int cyc = 1; cyc <= 4 * PL; cyc++) begin
      if (fill_valid) begin
        if (first_fill == 0) first_fill = cyc;
        if (idx < exp_q.size()) begin
          checkOutput("fill_price", 64'(fill_price), 64'(exp_q[idx].price));
          checkOutput("fill_qty", 64'(fill_qty), exp_q[idx].qty);
        end else begin
          checkOutput("fill_extra", 64'(idx + 1), 64'(exp_q.size()));
        end
        idx++;
      end
      if (match_done) begin
        checkOutput("match_residual", 64'(match_residual), rem);
        checkOutput("fills_seen", 64'(idx), 64'(exp_q.size()));
        done_cycle = cyc;
        break;
      end
      tick();
    end
    checkOutput("match_done_seen", 64'(done_cycle != 0), 64'd1);
    if (exp_q.size() == 0) checkOutput("nocross_done_latency", 64'(done_cycle), 64'd1);
    else                   checkOutput("first_fill_latency", 64'(first_fill), 64'd1);
    tick();
    checkOutput("match_ready", 64'(in_ready), 64'd1);
    checkBook("match");
  endtask

  task automatic doReset();
    reset = 1'b0;
    tick();
    checkReset("reset");
    clearModel();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int cyc;
    int dones;
    int r;
    int s;
    int p;
    int q;

    $display("[TB] level_book test start");
    clearModel();
    reset = 1'b0;
    tick();
    tick();
    checkReset("por");
    reset = 1'b1;
    tick();

    // Two bids: the higher one becomes best.
    doAdd(1'b0, 10, 5);
    doAdd(1'b0, 12, 3);
    checkOutput("tp1_best_bid", 64'(best_bid), 64'd12);

    // Buy sweeps 20 fully and 21 partially.
    doAdd(1'b1, 20, 4);
    doAdd(1'b1, 21, 6);
    doMatch(1'b0, 21, 7, cyc);
    checkOutput("tp2_best_ask", 64'(best_ask), 64'd21);
    doCancel(1'b1, 21, 3, cyc);
    checkOutput("tp2_ask_empty", 64'(ask_valid), 64'd0);

    // Buy exhausts the ask side and scans to the end.
    doAdd(1'b1, 20, 4);
    doMatch(1'b0, 25, 10, cyc);
    checkOutput("tp3_ask_valid", 64'(ask_valid), 64'd0);

    // Sell above the best bid: nothing crosses.
    doAdd(1'b0, 30, 5);
    doMatch(1'b1, 31, 2, cyc);

    // Cancel best bid triggers a short scan; an oversized cancel is rejected.
    doAdd(1'b0, 50, 5);
    doAdd(1'b0, 40, 1);
    doCancel(1'b0, 50, 5, cyc);
    checkOutput("tp5_scan_within_11", 64'(cyc <= 11), 64'd1);
    checkOutput("tp5_best_bid", 64'(best_bid), 64'd40);
    doCancel(1'b0, 40, 2, cyc);
    doCancel(1'b0, 40, 1, cyc);

    applyStimulus(OP_RSVD, 1'b0, 5, 5);
    checkOutput("rsvd_error", 64'(error), 64'd1);
    checkBook("rsvd");

    // Quantity overflow on a single level.
    doReset();
    doAdd(1'b0, 0, QMAX);
    doAdd(1'b0, 0, 1);
    tick();
    checkOutput("error_one_pulse", 64'(error), 64'd0);

    // Reset in the middle of a long scan entered from a match.
    doReset();
    doAdd(1'b1, 0, 1);
    applyStimulus(OP_MATCH, 1'b0, 255, 5);
    checkOutput("midscan_fill_valid", 64'(fill_valid), 64'd1);
    checkOutput("midscan_fill_price", 64'(fill_price), 64'd0);
    checkOutput("midscan_fill_qty", 64'(fill_qty), 64'd1);
    dones = 0;
    repeat (20) begin
      tick();
      if (match_done) dones++;
    end
    checkOutput("midscan_busy", 64'(in_ready), 64'd0);
    checkOutput("midscan_no_done_before", 64'(dones), 64'd0);
    reset = 1'b0;
    tick();
    checkReset("midscan_reset");
    clearModel();
    reset = 1'b1;
    dones = 0;
    repeat (5) begin
      tick();
      if (match_done) dones++;
    end
    checkOutput("midscan_no_done_after", 64'(dones), 64'd0);
    checkBook("midscan");

    // Random traffic around a crossing price band.
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 19));
      s = int'($urandom_range(0, 1));
      if (r < 8) begin
        p = (s != 0) ? int'($urandom_range(104, 120)) : int'($urandom_range(96, 112));
        q = int'($urandom_range(0, 20));
        doAdd(s[0], p, longint'(q));
      end else if (r < 12) begin
        p = (s != 0) ? int'($urandom_range(104, 120)) : int'($urandom_range(96, 112));
        q = int'($urandom_range(0, 32'(getLvl(s[0], p)) + 1));
        doCancel(s[0], p, longint'(q), cyc);
      end else if (r < 19) begin
        p = int'($urandom_range(96, 120));
        q = int'($urandom_range(0, 30));
        doMatch(s[0], p, longint'(q), cyc);
      end else begin
        applyStimulus(OP_RSVD, s[0], 100, 1);
        checkOutput("rand_rsvd_error", 64'(error), 64'd1);
        checkBook("rand_rsvd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
